// File: rtl/conv_block_fixed_pipe.sv
// Pipelined signed K x K convolution with double-buffered kernel, round/saturate to OUT_BITS.
// Build option: define CONV_ROUND_EN for round-half-up before the shift; otherwise the shift floors.
module conv_block_fixed_pipe #(
    parameter int NBIT        = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int COEF_BITS   = 12,
    parameter int FRAC_BITS   = 10,
    parameter int OUT_BITS    = 8
) (
    input  logic                                        i_clk,
    input  logic                                        i_rst_n,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*NBIT-1:0]      i_data,
    input  logic                                        i_data_valid,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*COEF_BITS-1:0] i_kernel,
    input  logic                                        i_kernel_valid,
    input  logic                                        i_kernel_commit,
    output logic [OUT_BITS-1:0]                         o_pixel,
    output logic                                        o_pixel_valid,
    output logic                                        o_sat,
    output logic                                        o_kernel_pending
);

    localparam int TAPS   = KERNEL_SIZE * KERNEL_SIZE;
    localparam int CENTRE = TAPS / 2;
    localparam int PROD_W = NBIT + COEF_BITS + 1;
    localparam int SUM_W  = PROD_W + $clog2(TAPS);
    localparam int RND_W  = SUM_W + 1;

    localparam logic [COEF_BITS-1:0]    COEF_ONE = COEF_BITS'(1) << FRAC_BITS;
    localparam logic signed [RND_W-1:0] PIX_MAX  = RND_W'((1 << OUT_BITS) - 1);
`ifdef CONV_ROUND_EN
    localparam logic signed [RND_W-1:0] RND_BIAS = RND_W'(1) << (FRAC_BITS - 1);
`else
    localparam logic signed [RND_W-1:0] RND_BIAS = '0;
`endif

    logic [COEF_BITS-1:0] active_q [TAPS];
    logic [COEF_BITS-1:0] shadow_q [TAPS];
    logic                 pending_q;

    // Load with commit bypasses the shadow so the new taps are live on the next edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                active_q[i] <= (i == CENTRE) ? COEF_ONE : '0;
                shadow_q[i] <= '0;
            end
            pending_q <= 1'b0;
        end else if (i_kernel_valid) begin
            for (int i = 0; i < TAPS; i++) begin
                shadow_q[i] <= i_kernel[i*COEF_BITS +: COEF_BITS];
            end
            if (i_kernel_commit) begin
                for (int i = 0; i < TAPS; i++) begin
                    active_q[i] <= i_kernel[i*COEF_BITS +: COEF_BITS];
                end
                pending_q <= 1'b0;
            end else begin
                pending_q <= 1'b1;
            end
        end else if (i_kernel_commit && pending_q) begin
            for (int i = 0; i < TAPS; i++) begin
                active_q[i] <= shadow_q[i];
            end
            pending_q <= 1'b0;
        end
    end

    assign o_kernel_pending = pending_q;

    logic signed [PROD_W-1:0] prod_c [TAPS];

    always_comb begin
        prod_c = '{default: '0};
        for (int i = 0; i < TAPS; i++) begin
            prod_c[i] = $signed({{(COEF_BITS+1){1'b0}}, i_data[i*NBIT +: NBIT]})
                      * $signed({{(NBIT+1){active_q[i][COEF_BITS-1]}}, active_q[i]});
        end
    end

    logic signed [PROD_W-1:0] prod_q [TAPS];
    logic                     v1_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v1_q <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            v1_q <= i_data_valid;
            if (i_data_valid) begin
                for (int i = 0; i < TAPS; i++) begin
                    prod_q[i] <= prod_c[i];
                end
            end
        end
    end

    logic signed [SUM_W-1:0] sum_c;
    logic signed [SUM_W-1:0] sum_q;
    logic                    v2_q;

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < TAPS; i++) begin
            sum_c = sum_c + $signed({{(SUM_W-PROD_W){prod_q[i][PROD_W-1]}}, prod_q[i]});
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sum_q <= '0;
            v2_q  <= 1'b0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                sum_q <= sum_c;
            end
        end
    end

    logic signed [RND_W-1:0] biased_c;
    logic signed [RND_W-1:0] shifted_c;
    logic [OUT_BITS-1:0]     pix_c;
    logic                    sat_c;

    always_comb begin
        biased_c  = $signed({sum_q[SUM_W-1], sum_q}) + RND_BIAS;
        shifted_c = biased_c >>> FRAC_BITS;
        pix_c     = shifted_c[OUT_BITS-1:0];
        sat_c     = 1'b0;
        if (shifted_c[RND_W-1]) begin
            pix_c = '0;
            sat_c = 1'b1;
        end else if (shifted_c > PIX_MAX) begin
            pix_c = '1;
            sat_c = 1'b1;
        end
    end

    logic [OUT_BITS-1:0] pix3_q;
    logic                sat3_q;
    logic                v3_q;

    // Products are formed on the sampling edge, so one more register after S3 gives latency 3.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pix3_q        <= '0;
            sat3_q        <= 1'b0;
            v3_q          <= 1'b0;
            o_pixel       <= '0;
            o_sat         <= 1'b0;
            o_pixel_valid <= 1'b0;
        end else begin
            v3_q          <= v2_q;
            o_pixel_valid <= v3_q;
            if (v2_q) begin
                pix3_q <= pix_c;
                sat3_q <= sat_c;
            end
            if (v3_q) begin
                o_pixel <= pix3_q;
                o_sat   <= sat3_q;
            end
        end
    end

endmodule

// File: tb/tb_conv_block_fixed_pipe.sv
// Bench for conv_block_fixed_pipe: vector table plus hand sequences, checked through a scoreboard.
module tb_conv_block_fixed_pipe;

    localparam int NBIT      = 8;
    localparam int K         = 3;
    localparam int COEF_BITS = 12;
    localparam int TAPS      = K * K;
`ifdef CONV_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic                        i_clk;
    logic                        i_rst_n;
    logic [TAPS*NBIT-1:0]        i_data;
    logic                        i_data_valid;
    logic [TAPS*COEF_BITS-1:0]   i_kernel;
    logic                        i_kernel_valid;
    logic                        i_kernel_commit;
    logic [7:0]                  o_pixel;
    logic                        o_pixel_valid;
    logic                        o_sat;
    logic                        o_kernel_pending;

    conv_block_fixed_pipe dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_data           (i_data),
        .i_data_valid     (i_data_valid),
        .i_kernel         (i_kernel),
        .i_kernel_valid   (i_kernel_valid),
        .i_kernel_commit  (i_kernel_commit),
        .o_pixel          (o_pixel),
        .o_pixel_valid    (o_pixel_valid),
        .o_sat            (o_sat),
        .o_kernel_pending (o_kernel_pending)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        int pix;
        bit sat;
        int sample_edge;
    } exp_t;

    typedef struct {
        int corner;
        int edg;
        int centre;
        int pix_c;
        int pix_o;
        int exp_pix;
        bit exp_sat;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t tbl[11];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge i_clk) begin
        if (o_pixel_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("pixel", int'(o_pixel), mon_e.pix);
                check("sat", int'(o_sat), int'(mon_e.sat));
                check("latency_edge", cyc, mon_e.sample_edge + 3);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
        $fatal(1);
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_window(input int pc, input int po);
        for (int i = 0; i < TAPS; i++) begin
            i_data[i*NBIT +: NBIT] = (i == TAPS/2) ? pc[7:0] : po[7:0];
        end
    endtask

    task automatic set_kernel(input int corner, input int edg, input int centre);
        int v;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                if (r == 1 && c == 1)      v = centre;
                else if (r == 1 || c == 1) v = edg;
                else                       v = corner;
                i_kernel[(r*K+c)*COEF_BITS +: COEF_BITS] = v[COEF_BITS-1:0];
            end
        end
    endtask

    task automatic expect_out(input int pix, input bit sat);
        exp_t e;
        e.pix         = pix;
        e.sat         = sat;
        e.sample_edge = cyc + 1;
        sb.push_back(e);
    endtask

    initial begin
        tbl[0]  = '{0,    0,    1024, 0,   0,   0,              1'b0};
        tbl[1]  = '{64,   128,  256,  100, 100, 100,            1'b0};
        tbl[2]  = '{0,    0,    512,  3,   0,   RND ? 2 : 1,    1'b0};
        tbl[3]  = '{0,    0,    1536, 200, 0,   255,            1'b1};
        tbl[4]  = '{0,    0,   -1024, 10,  0,   0,              1'b1};
        tbl[5]  = '{0,   -256,  1024, 120, 100, 20,             1'b0};
        tbl[6]  = '{0,    0,    1023, 100, 0,   RND ? 100 : 99, 1'b0};
        tbl[7]  = '{0,    0,    1024, 255, 0,   255,            1'b0};
        tbl[8]  = '{0,    0,    1028, 255, 0,   255,            RND};
        tbl[9]  = '{0,   -256,  1024, 101, 102, 0,              1'b1};
        tbl[10] = '{0,    0,   -512,  1,   0,   0,              !RND};

        i_rst_n         = 1'b0;
        i_data          = '0;
        i_data_valid    = 1'b0;
        i_kernel        = '0;
        i_kernel_valid  = 1'b0;
        i_kernel_commit = 1'b0;
        repeat (3) tick();
        i_rst_n = 1'b1;

        check("reset_pixel", int'(o_pixel), 0);
        check("reset_valid", int'(o_pixel_valid), 0);
        check("reset_sat", int'(o_sat), 0);
        check("reset_pending", int'(o_kernel_pending), 0);

        // Identity kernel straight out of reset.
        set_window(200, 50);
        i_data_valid = 1'b1;
        expect_out(200, 1'b0);
        tick();
        i_data_valid = 1'b0;
        repeat (6) tick();

        // Table: each window shares its sampling edge with the bypass load of the next kernel.
        set_kernel(tbl[0].corner, tbl[0].edg, tbl[0].centre);
        i_kernel_valid  = 1'b1;
        i_kernel_commit = 1'b1;
        tick();
        for (int i = 0; i < 11; i++) begin
            set_window(tbl[i].pix_c, tbl[i].pix_o);
            i_data_valid = 1'b1;
            expect_out(tbl[i].exp_pix, tbl[i].exp_sat);
            if (i < 10) begin
                set_kernel(tbl[i+1].corner, tbl[i+1].edg, tbl[i+1].centre);
            end else begin
                i_kernel_valid  = 1'b0;
                i_kernel_commit = 1'b0;
            end
            tick();
            check("bypass_pending", int'(o_kernel_pending), 0);
        end
        i_data_valid = 1'b0;
        repeat (6) tick();

        // Gaussian through shadow load then separate commit.
        set_kernel(64, 128, 256);
        i_kernel_valid = 1'b1;
        tick();
        i_kernel_valid = 1'b0;
        check("gauss_pending_set", int'(o_kernel_pending), 1);
        i_kernel_commit = 1'b1;
        tick();
        i_kernel_commit = 1'b0;
        check("gauss_pending_clr", int'(o_kernel_pending), 0);
        set_window(100, 100);
        for (int i = 0; i < 4; i++) begin
            i_data_valid = 1'b1;
            expect_out(100, 1'b0);
            tick();
        end
        i_data_valid = 1'b0;
        repeat (6) tick();

        // Commit mid-stream: window on the commit edge still sees the old bank.
        set_kernel(0, 0, 1024);
        i_kernel_valid  = 1'b1;
        i_kernel_commit = 1'b1;
        tick();
        i_kernel_commit = 1'b0;
        set_kernel(0, 0, 512);
        tick();
        i_kernel_valid = 1'b0;
        check("mid_pending_set", int'(o_kernel_pending), 1);
        set_window(100, 100);
        i_data_valid = 1'b1;
        expect_out(100, 1'b0);
        tick();
        i_kernel_commit = 1'b1;
        expect_out(100, 1'b0);
        tick();
        i_kernel_commit = 1'b0;
        expect_out(50, 1'b0);
        tick();
        check("mid_pending_clr", int'(o_kernel_pending), 0);
        i_kernel_commit = 1'b1;
        expect_out(50, 1'b0);
        tick();
        i_kernel_commit = 1'b0;
        expect_out(50, 1'b0);
        tick();
        i_data_valid = 1'b0;
        repeat (6) tick();

        // Reset with two windows in flight, non-identity kernel active.
        set_kernel(0, 0, 512);
        i_kernel_valid  = 1'b1;
        i_kernel_commit = 1'b1;
        tick();
        i_kernel_valid  = 1'b0;
        i_kernel_commit = 1'b0;
        set_window(200, 200);
        i_data_valid = 1'b1;
        tick();
        tick();
        i_data_valid = 1'b0;
        i_rst_n      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst_valid", int'(o_pixel_valid), 0);
            check("rst_pixel", int'(o_pixel), 0);
        end
        check("rst_sat", int'(o_sat), 0);
        i_rst_n = 1'b1;
        tick();
        check("rst_pending", int'(o_kernel_pending), 0);
        // Commit with nothing pending must not copy the cleared shadow.
        i_kernel_commit = 1'b1;
        tick();
        i_kernel_commit = 1'b0;
        set_window(77, 50);
        i_data_valid = 1'b1;
        expect_out(77, 1'b0);
        tick();
        i_data_valid = 1'b0;

        for (int w = 0; w < 20 && sb.size() != 0; w++) tick();
        repeat (3) tick();
        check("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_block_fixed_pipe.md
# conv_block_fixed_pipe

Pipelined fixed-point K×K convolution engine. It replaces the single-cycle Gaussian convolution block in the filter chain between the line-buffer window generator and the gradient/NMS stages. Generalisations over that block:
- signed kernel coefficients (Gaussian, Sobel and Laplacian on one engine)
- double-buffered kernel with an explicit commit
- registered three-stage pipeline with a valid strobe
- rounding and saturation to a configurable output width

## Interface
Parameters:
- NBIT, 8, unsigned pixel width
- KERNEL_SIZE, 3, kernel side K; odd, 3..7
- COEF_BITS, 12, signed two's-complement coefficient width; must be ≥ FRAC_BITS+2
- FRAC_BITS, 10, fractional bits of each coefficient
- OUT_BITS, 8, unsigned output pixel width

Ports:
- i_clk  in  1  clock; all state changes on the rising edge
- i_rst_n  in  1  reset; asynchronous assert, active low
- i_data  in  [NBIT-1:0] × [K][K]  pixel window, unsigned
- i_data_valid  in  1  window is sampled on this edge
- i_kernel  in  [COEF_BITS-1:0] × [K][K]  coefficients to load
- i_kernel_valid  in  1  write i_kernel into the shadow bank
- i_kernel_commit  in  1  copy the shadow bank to the active bank
- o_pixel  out  OUT_BITS  result
- o_pixel_valid  out  1  o_pixel is valid this cycle
- o_sat  out  1  the result was clamped; qualified by o_pixel_valid
- o_kernel_pending  out  1  shadow bank is loaded but not yet committed

## Operation
Kernel banks:
- Reset loads the active bank with identity: centre tap = 1<<FRAC_BITS, all other taps 0. The shadow bank is cleared and pending = 0.
- i_kernel_valid only: shadow ← i_kernel, pending ← 1.
- i_kernel_commit with pending = 1: active ← shadow, pending ← 0.
- i_kernel_commit with pending = 0: ignored.
- i_kernel_valid and i_kernel_commit in the same cycle: active ← i_kernel (bypass), shadow ← i_kernel, pending ← 0.
- A window sampled on the same edge as a commit uses the old active bank. The first window to use the new bank is the one sampled on the following edge.

Pipeline (no backpressure; one window per cycle is accepted):
- S1: K² signed products of zero-extended pixel × active coefficient, each NBIT+COEF_BITS+1 bits, registered.
- S2: reduction-tree sum, registered; width NBIT+COEF_BITS+1+$clog2(K²); no overflow is possible.
- S3: round, arithmetic shift right by FRAC_BITS, saturate; registered to o_pixel.
- Saturation: a shifted value < 0 gives 0; a value > 2^OUT_BITS−1 gives 2^OUT_BITS−1. Either case sets o_sat = 1, otherwise o_sat = 0.
- A valid bit travels alongside each stage. Stage registers of invalid slots hold their previous value.

Reset mid-operation:
- All valid bits clear immediately, so in-flight windows are dropped.
- o_pixel, o_sat and o_pixel_valid go to 0.
- Kernel banks return to their reset values.

## Timing
- Latency is 3 cycles. A window sampled with i_data_valid at edge n produces o_pixel_valid = 1 for exactly the cycle after edge n+3.
- Throughput is 1 window per cycle. Gaps in i_data_valid propagate unchanged.
- Reset values: o_pixel = 0, o_pixel_valid = 0, o_sat = 0, o_kernel_pending = 0.
- o_kernel_pending updates on the edge that loads or commits.
- The kernel inputs are independent of the data stream; a load or commit may occur on any cycle.

## Configuration
- CONV_ROUND_EN defined: S3 adds 2^(FRAC_BITS−1) before the shift, giving round-half-up (toward +∞).
- CONV_ROUND_EN undefined: S3 is a plain arithmetic shift, i.e. floor.
- Latency and all other behaviour are identical in both builds.

## Test plan
All scenarios use default parameters.
1. Identity after reset: release reset; send one window with centre = 200 and all other pixels 50, valid at edge 0. Required: o_pixel = 200, o_sat = 0, valid for one cycle after edge 3, and no valid at any other time.
2. Gaussian kernel: load [64 128 64; 128 256 128; 64 128 64] with a commit; stream 4 windows of all pixels 100. Required: 4 consecutive outputs of 100; pending goes 1→0.
3. Rounding: kernel with centre = 512, others 0; pixel = 3. Required: output 2 with CONV_ROUND_EN defined, 1 without.
4. Saturation: centre = 1536 with pixel 200 gives 255 and o_sat = 1. Centre = −1024 with pixel 10 gives 0 and o_sat = 1.
5. Commit mid-stream: shadow loaded with centre = 512; all-100 windows at edges 0, 1, 2; commit at edge 1. Required: outputs 100, 100, 50 on consecutive cycles. Also, a commit with pending = 0 leaves the outputs unchanged.
6. Reset in flight: windows at edges 0 and 1; assert i_rst_n low between edges 1 and 2. Required: o_pixel_valid stays 0 and o_pixel = 0; after release, a centre = 77 window returns 77 (identity restored).
